// File: rtl/rsa256_avalon_wrapper.sv
// Avalon-MM UART master for the RSA256 decryptor: collects N, d and ciphertext, runs the core, returns plaintext.
// Define RSA_WRAP_FULL_OUT_EN to send all 32 result bytes instead of the low 31.
module rsa256_avalon_wrapper #(
  parameter logic [4:0] RX_BASE     = 5'd0,
  parameter logic [4:0] TX_BASE     = 5'd4,
  parameter logic [4:0] STATUS_BASE = 5'd8,
  parameter int         RX_OK_BIT   = 7,
  parameter int         TX_OK_BIT   = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  output logic [4:0]   avm_address,
  output logic         avm_read,
  input  logic [31:0]  avm_readdata,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  input  logic         avm_waitrequest,
  output logic         o_core_start,
  output logic [255:0] o_core_n,
  output logic [255:0] o_core_d,
  output logic [255:0] o_core_a,
  input  logic [255:0] i_core_result,
  input  logic         i_core_finished
);

  typedef enum logic [1:0] {S_GET_KEY, S_GET_DATA, S_WAIT_CALC, S_SEND_DATA} state_t;

`ifdef RSA_WRAP_FULL_OUT_EN
  localparam logic [4:0] LAST_TX = 5'd31;
`else
  localparam logic [4:0] LAST_TX = 5'd30;
`endif

  state_t       state_q, state_d;
  logic         key_phase_q, key_phase_d;
  logic         xfer_q, xfer_d;
  logic [4:0]   byte_cnt_q, byte_cnt_d;
  logic [4:0]   addr_q, addr_d;
  logic         read_q, read_d;
  logic         write_q, write_d;
  logic         start_q, start_d;
  logic [7:0]   wdata_q, wdata_d;
  logic [255:0] n_q, n_d, d_q, d_d, a_q, a_d, out_q, out_d;
  logic [7:0]   rx_byte;
  logic         bus_done;
  logic         unused_bits;

  assign rx_byte       = avm_readdata[7:0];
  assign bus_done      = (read_q || write_q) && !avm_waitrequest;
  assign unused_bits   = ^{avm_readdata[31:8], i_core_result[255:248]};

  assign avm_address   = addr_q;
  assign avm_read      = read_q;
  assign avm_write     = write_q;
  assign avm_writedata = {24'b0, wdata_q};
  assign o_core_start  = start_q;
  assign o_core_n      = n_q;
  assign o_core_d      = d_q;
  assign o_core_a      = a_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_GET_KEY;
      key_phase_q <= 1'b0;
      xfer_q      <= 1'b0;
      byte_cnt_q  <= 5'd0;
      addr_q      <= STATUS_BASE;
      read_q      <= 1'b1;
      write_q     <= 1'b0;
      start_q     <= 1'b0;
      wdata_q     <= 8'd0;
      n_q         <= '0;
      d_q         <= '0;
      a_q         <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      key_phase_q <= key_phase_d;
      xfer_q      <= xfer_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
      write_q     <= write_d;
      start_q     <= start_d;
      wdata_q     <= wdata_d;
      n_q         <= n_d;
      d_q         <= d_d;
      a_q         <= a_d;
      out_q       <= out_d;
    end
  end

  // xfer_q selects between the status poll and the data access of each byte loop.
  always_comb begin
    state_d     = state_q;
    key_phase_d = key_phase_q;
    xfer_d      = xfer_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    read_d      = read_q;
    write_d     = write_q;
    start_d     = 1'b0;
    wdata_d     = wdata_q;
    n_d         = n_q;
    d_d         = d_q;
    a_d         = a_q;
    out_d       = out_q;

    case (state_q)
      S_GET_KEY, S_GET_DATA: begin
        if (bus_done && !xfer_q) begin
          if (avm_readdata[RX_OK_BIT]) begin
            xfer_d = 1'b1;
            addr_d = RX_BASE;
          end
        end else if (bus_done) begin
          xfer_d     = 1'b0;
          addr_d     = STATUS_BASE;
          byte_cnt_d = byte_cnt_q + 5'd1;
          if (state_q == S_GET_DATA) begin
            a_d = {a_q[247:0], rx_byte};
            if (byte_cnt_q == 5'd31) begin
              start_d = 1'b1;
              read_d  = 1'b0;
              state_d = S_WAIT_CALC;
            end
          end else if (!key_phase_q) begin
            n_d = {n_q[247:0], rx_byte};
            if (byte_cnt_q == 5'd31) key_phase_d = 1'b1;
          end else begin
            d_d = {d_q[247:0], rx_byte};
            if (byte_cnt_q == 5'd31) state_d = S_GET_DATA;
          end
        end
      end

      S_WAIT_CALC: begin
        if (i_core_finished) begin
`ifdef RSA_WRAP_FULL_OUT_EN
          out_d = i_core_result;
`else
          // Top byte is always zero because N < 2^248, so it is skipped here.
          out_d = {i_core_result[247:0], 8'h00};
`endif
          state_d    = S_SEND_DATA;
          read_d     = 1'b1;
          addr_d     = STATUS_BASE;
          xfer_d     = 1'b0;
          byte_cnt_d = 5'd0;
        end
      end

      S_SEND_DATA: begin
        if (bus_done && !xfer_q) begin
          if (avm_readdata[TX_OK_BIT]) begin
            read_d  = 1'b0;
            write_d = 1'b1;
            addr_d  = TX_BASE;
            wdata_d = out_q[255:248];
            xfer_d  = 1'b1;
          end
        end else if (bus_done) begin
          write_d    = 1'b0;
          read_d     = 1'b1;
          addr_d     = STATUS_BASE;
          xfer_d     = 1'b0;
          out_d      = out_q << 8;
          byte_cnt_d = byte_cnt_q + 5'd1;
          if (byte_cnt_q == LAST_TX) begin
            state_d    = S_GET_DATA;
            byte_cnt_d = 5'd0;
          end
        end
      end

      default: state_d = S_GET_KEY;
    endcase
  end

endmodule

// File: tb/tb_rsa256_avalon_wrapper.sv
// Bench for rsa256_avalon_wrapper: UART slave model with random stalls, 20-cycle stub core,
// byte-level reference model for N/d/a and the transmitted plaintext.
module tb_rsa256_avalon_wrapper;

`ifdef RSA_WRAP_FULL_OUT_EN
  localparam int TX_BYTES = 32;
  localparam bit FULL_OUT = 1'b1;
`else
  localparam int TX_BYTES = 31;
  localparam bit FULL_OUT = 1'b0;
`endif

  localparam logic [255:0] KNOWN_N   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KNOWN_D   = 256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f;
  localparam logic [255:0] KNOWN_A   = 256'h404142434445464748494a4b4c4d4e4f505152535455565758595a5b5c5d5e5f;
  localparam logic [255:0] KNOWN_RES = 256'haa0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         i_clk;
  logic         i_rst;
  logic [4:0]   avm_address;
  logic         avm_read;
  logic [31:0]  avm_readdata;
  logic         avm_write;
  logic [31:0]  avm_writedata;
  logic         avm_waitrequest;
  logic         o_core_start;
  logic [255:0] o_core_n;
  logic [255:0] o_core_d;
  logic [255:0] o_core_a;
  logic [255:0] i_core_result;
  logic         i_core_finished;

  int checks;
  int failures;

  logic [7:0]   rx_q[$];
  logic [7:0]   tx_log[$];
  logic [7:0]   exp_tx[$];
  logic [255:0] exp_a_q[$];
  logic [255:0] result_q[$];
  logic [255:0] exp_n;
  logic [255:0] exp_d;
  int rx_block;
  int polls_since_rx;
  int last_polls;
  int rx_reads;
  int pop_total;
  int force_tx_wait;
  int forced_stalls;
  bit forced_done;
  int start_cnt;

  rsa256_avalon_wrapper dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .o_core_start    (o_core_start),
    .o_core_n        (o_core_n),
    .o_core_d        (o_core_d),
    .o_core_a        (o_core_a),
    .i_core_result   (i_core_result),
    .i_core_finished (i_core_finished)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // UART slave and stub core; both act on the falling edge so the DUT samples settled inputs.
  initial begin : bus_and_core_models
    logic [31:0]  rnd;
    logic [38:0]  snap;
    logic [255:0] res;
    logic [255:0] cap_n, cap_d, cap_a;
    logic [7:0]   b;
    bit busy, stall_prev, pop_prev, start_prev, forced_now, rx_ok, exp_start;
    int wait_left, pending;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'd0;
    i_core_finished = 1'b0;
    i_core_result   = '0;
    busy = 0; stall_prev = 0; pop_prev = 0; start_prev = 0; forced_now = 0;
    wait_left = 0; pending = 0; snap = '0; cap_n = '0; cap_d = '0; cap_a = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        busy = 0; stall_prev = 0; pop_prev = 0; start_prev = 0; forced_now = 0;
        wait_left = 0; pending = 0; pop_total = 0;
        avm_waitrequest = 1'b0;
        i_core_finished = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if ({avm_address, avm_read, avm_write, avm_writedata} !== snap)
            begin failures++; $display("[TB] FAIL stall_hold: got %h expected %h", {avm_address, avm_read, avm_write, avm_writedata}, snap); end
        end
        if (pop_prev) begin
          exp_start = (pop_total > 64) && ((pop_total - 64) % 32 == 0);
          checks++;
          if (o_core_start !== exp_start)
            begin failures++; $display("[TB] FAIL start_after_byte%0d: got %b expected %b", pop_total, o_core_start, exp_start); end
        end
        stall_prev = 0;
        pop_prev   = 0;

        if (avm_read || avm_write) begin
          checks++;
          if (avm_read && avm_write)
            begin failures++; $display("[TB] FAIL rw_exclusive: got read=1 write=1 expected one of them"); end
          if (!busy) begin
            busy = 1;
            if (avm_write && force_tx_wait > 0) begin
              wait_left = force_tx_wait; force_tx_wait = 0; forced_now = 1;
            end else begin
              wait_left = $urandom_range(0, 3); forced_now = 0;
            end
          end
          if (wait_left > 0) begin
            wait_left--;
            avm_waitrequest = 1'b1;
            avm_readdata    = $urandom();
            stall_prev      = 1;
            snap            = {avm_address, avm_read, avm_write, avm_writedata};
            if (forced_now) forced_stalls++;
          end else begin
            avm_waitrequest = 1'b0;
            busy = 0;
            if (forced_now) forced_done = 1;
            forced_now = 0;
            rnd = $urandom();
            if (avm_read && avm_address == 5'd8) begin
              if (rx_block > 0) begin rx_ok = 0; rx_block--; end
              else begin rx_ok = (rx_q.size() > 0); polls_since_rx++; end
              rnd[7] = rx_ok;
              rnd[6] = ($urandom_range(0, 3) != 0);
              avm_readdata = rnd;
            end else if (avm_read && avm_address == 5'd0) begin
              rx_reads++;
              last_polls = polls_since_rx;
              polls_since_rx = 0;
              if (rx_q.size() == 0) begin
                failures++; $display("[TB] FAIL rx_underflow: got RX read expected none");
                avm_readdata = rnd;
              end else begin
                b = rx_q.pop_front();
                avm_readdata = {rnd[31:8], b};
                pop_total++;
                pop_prev = 1;
              end
            end else if (avm_write && avm_address == 5'd4) begin
              checks++;
              if (avm_writedata[31:8] !== 24'd0)
                begin failures++; $display("[TB] FAIL writedata_upper: got %h expected 000000", avm_writedata[31:8]); end
              tx_log.push_back(avm_writedata[7:0]);
            end else begin
              failures++; $display("[TB] FAIL bus_address: got %0d read=%b write=%b expected a UART register", avm_address, avm_read, avm_write);
            end
          end
        end else begin
          avm_waitrequest = 1'b0;
          busy = 0;
        end

        if (i_core_finished) begin
          checks++;
          if (avm_read !== 1'b1 || avm_write !== 1'b0 || avm_address !== 5'd8)
            begin failures++; $display("[TB] FAIL status_after_finished: got addr=%0d rd=%b wr=%b expected addr=8 rd=1 wr=0", avm_address, avm_read, avm_write); end
          checks++;
          if ({o_core_n, o_core_d, o_core_a} !== {cap_n, cap_d, cap_a})
            begin failures++; $display("[TB] FAIL core_inputs_held: got a=%h expected a=%h", o_core_a, cap_a); end
          i_core_finished = 1'b0;
        end
        if (o_core_start) begin
          if (start_prev) begin failures++; $display("[TB] FAIL start_width: got 2+ cycles expected 1"); end
          start_cnt++;
          cap_n = o_core_n; cap_d = o_core_d; cap_a = o_core_a;
          checks += 3;
          if (o_core_n !== exp_n) begin failures++; $display("[TB] FAIL core_n: got %h expected %h", o_core_n, exp_n); end
          if (o_core_d !== exp_d) begin failures++; $display("[TB] FAIL core_d: got %h expected %h", o_core_d, exp_d); end
          if (exp_a_q.size() == 0) begin failures++; $display("[TB] FAIL unexpected_start: got pulse expected none"); end
          else begin
            res = exp_a_q.pop_front();
            if (o_core_a !== res) begin failures++; $display("[TB] FAIL core_a: got %h expected %h", o_core_a, res); end
          end
          pending = 20;
        end
        start_prev = o_core_start;
        if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            if (result_q.size() > 0) res = result_q.pop_front();
            else for (int i = 0; i < 8; i++) res = {res[223:0], 32'($urandom())};
            i_core_result   = res;
            i_core_finished = 1'b1;
            for (int k = (FULL_OUT ? 0 : 1); k < 32; k++) exp_tx.push_back(res[255 - 8 * k -: 8]);
          end
        end
      end
    end
  end

  task automatic push_random_block(output logic [255:0] v);
    logic [7:0] b;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_q.push_back(b);
      v = (v << 8) | 256'(b);
    end
  endtask

  task automatic wait_tx(input int n, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge i_clk); #2;
      if (tx_log.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checks += 8;
    if (avm_address !== 5'd8)     begin failures++; $display("[TB] FAIL reset_address: got %0d expected 8", avm_address); end
    if (avm_read !== 1'b1)        begin failures++; $display("[TB] FAIL reset_read: got %b expected 1", avm_read); end
    if (avm_write !== 1'b0)       begin failures++; $display("[TB] FAIL reset_write: got %b expected 0", avm_write); end
    if (avm_writedata !== 32'd0)  begin failures++; $display("[TB] FAIL reset_writedata: got %h expected 0", avm_writedata); end
    if (o_core_start !== 1'b0)    begin failures++; $display("[TB] FAIL reset_start: got %b expected 0", o_core_start); end
    if (o_core_n !== '0)          begin failures++; $display("[TB] FAIL reset_n: got %h expected 0", o_core_n); end
    if (o_core_d !== '0)          begin failures++; $display("[TB] FAIL reset_d: got %h expected 0", o_core_d); end
    if (o_core_a !== '0)          begin failures++; $display("[TB] FAIL reset_a: got %h expected 0", o_core_a); end
    @(posedge i_clk); #2;
    i_rst = 1'b1;
  endtask

  task automatic test_known_vectors();
    int  s0;
    bit  ok;
    logic [7:0] e;
    @(posedge i_clk); #2;
    exp_n = KNOWN_N;
    exp_d = KNOWN_D;
    exp_a_q.push_back(KNOWN_A);
    result_q.push_back(KNOWN_RES);
    s0 = start_cnt;
    for (int i = 0; i < 96; i++) rx_q.push_back(8'(i));
    wait_tx(TX_BYTES, 10000, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL known_tx_timeout: got %0d bytes expected %0d", tx_log.size(), TX_BYTES); end
    repeat (30) @(posedge i_clk);
    #2;
    checks += 5;
    if (start_cnt - s0 != 1)     begin failures++; $display("[TB] FAIL known_start_count: got %0d expected 1", start_cnt - s0); end
    if (o_core_n !== KNOWN_N)    begin failures++; $display("[TB] FAIL known_n: got %h expected %h", o_core_n, KNOWN_N); end
    if (o_core_d !== KNOWN_D)    begin failures++; $display("[TB] FAIL known_d: got %h expected %h", o_core_d, KNOWN_D); end
    if (o_core_a !== KNOWN_A)    begin failures++; $display("[TB] FAIL known_a: got %h expected %h", o_core_a, KNOWN_A); end
    if (tx_log.size() != TX_BYTES) begin failures++; $display("[TB] FAIL known_tx_count: got %0d expected %0d", tx_log.size(), TX_BYTES); end
    for (int i = 0; i < tx_log.size() && i < TX_BYTES; i++) begin
      e = FULL_OUT ? ((i == 0) ? 8'hAA : 8'(i)) : 8'(i + 1);
      checks++;
      if (tx_log[i] !== e) begin failures++; $display("[TB] FAIL known_tx_byte%0d: got %h expected %h", i, tx_log[i], e); end
    end
    tx_log.delete();
    exp_tx.delete();
  endtask

  task automatic test_rx_stall();
    logic [255:0] a_before, a_new;
    int  r0, s0;
    bit  ok;
    @(posedge i_clk); #2;
    a_before = o_core_a;
    r0 = rx_reads;
    s0 = start_cnt;
    polls_since_rx = 0;
    rx_block = 50;
    push_random_block(a_new);
    exp_a_q.push_back(a_new);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge i_clk); #2;
      if (rx_block == 0) begin ok = 1; break; end
    end
    checks += 3;
    if (!ok)               begin failures++; $display("[TB] FAIL rx_block_timeout: got %0d polls left expected 0", rx_block); end
    if (rx_reads != r0)    begin failures++; $display("[TB] FAIL rx_read_while_blocked: got %0d reads expected 0", rx_reads - r0); end
    if (o_core_a !== a_before) begin failures++; $display("[TB] FAIL shift_while_blocked: got %h expected %h", o_core_a, a_before); end
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge i_clk); #2;
      if (rx_reads != r0) begin ok = 1; break; end
    end
    checks++;
    if (!ok || last_polls != 1) begin failures++; $display("[TB] FAIL polls_before_accept: got %0d expected 1", last_polls); end
    wait_tx(TX_BYTES, 10000, ok);
    repeat (30) @(posedge i_clk);
    #2;
    checks += 2;
    if (start_cnt - s0 != 1) begin failures++; $display("[TB] FAIL stall_start_count: got %0d expected 1", start_cnt - s0); end
    if (tx_log.size() != TX_BYTES) begin failures++; $display("[TB] FAIL stall_tx_count: got %0d expected %0d", tx_log.size(), TX_BYTES); end
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++) begin
      checks++;
      if (tx_log[i] !== exp_tx[i]) begin failures++; $display("[TB] FAIL stall_tx_byte%0d: got %h expected %h", i, tx_log[i], exp_tx[i]); end
    end
    tx_log.delete();
    exp_tx.delete();
  endtask

  task automatic test_back_to_back();
    logic [255:0] a1, a2;
    int  s0;
    bit  ok;
    @(posedge i_clk); #2;
    s0 = start_cnt;
    push_random_block(a1);
    push_random_block(a2);
    exp_a_q.push_back(a1);
    exp_a_q.push_back(a2);
    wait_tx(2 * TX_BYTES, 20000, ok);
    repeat (30) @(posedge i_clk);
    #2;
    checks += 2;
    if (start_cnt - s0 != 2) begin failures++; $display("[TB] FAIL b2b_start_count: got %0d expected 2", start_cnt - s0); end
    if (tx_log.size() != 2 * TX_BYTES) begin failures++; $display("[TB] FAIL b2b_tx_count: got %0d expected %0d", tx_log.size(), 2 * TX_BYTES); end
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++) begin
      checks++;
      if (tx_log[i] !== exp_tx[i]) begin failures++; $display("[TB] FAIL b2b_tx_byte%0d: got %h expected %h", i, tx_log[i], exp_tx[i]); end
    end
    tx_log.delete();
    exp_tx.delete();
  endtask

  task automatic test_tx_stall();
    logic [255:0] a_new;
    bit ok;
    @(posedge i_clk); #2;
    forced_stalls = 0;
    forced_done   = 0;
    force_tx_wait = 5;
    push_random_block(a_new);
    exp_a_q.push_back(a_new);
    wait_tx(TX_BYTES, 10000, ok);
    repeat (30) @(posedge i_clk);
    #2;
    checks += 2;
    if (!forced_done || forced_stalls != 5) begin failures++; $display("[TB] FAIL tx_forced_stall: got %0d stalled cycles done=%b expected 5 done=1", forced_stalls, forced_done); end
    if (tx_log.size() != TX_BYTES) begin failures++; $display("[TB] FAIL txstall_tx_count: got %0d expected %0d", tx_log.size(), TX_BYTES); end
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++) begin
      checks++;
      if (tx_log[i] !== exp_tx[i]) begin failures++; $display("[TB] FAIL txstall_tx_byte%0d: got %h expected %h", i, tx_log[i], exp_tx[i]); end
    end
    tx_log.delete();
    exp_tx.delete();
  endtask

  task automatic test_reset_mid_send();
    logic [255:0] a_new, n_new, d_new;
    int  s0;
    bit  ok;
    @(posedge i_clk); #2;
    push_random_block(a_new);
    exp_a_q.push_back(a_new);
    wait_tx(3, 10000, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL midsend_timeout: got %0d bytes expected 3", tx_log.size()); end
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    checks += 6;
    if (avm_address !== 5'd8 || avm_read !== 1'b1) begin failures++; $display("[TB] FAIL midrst_bus: got addr=%0d rd=%b expected addr=8 rd=1", avm_address, avm_read); end
    if (avm_write !== 1'b0)      begin failures++; $display("[TB] FAIL midrst_write: got %b expected 0", avm_write); end
    if (avm_writedata !== 32'd0) begin failures++; $display("[TB] FAIL midrst_writedata: got %h expected 0", avm_writedata); end
    if (o_core_start !== 1'b0)   begin failures++; $display("[TB] FAIL midrst_start: got %b expected 0", o_core_start); end
    if (o_core_n !== '0 || o_core_d !== '0) begin failures++; $display("[TB] FAIL midrst_key: got n=%h expected 0", o_core_n); end
    if (o_core_a !== '0)         begin failures++; $display("[TB] FAIL midrst_a: got %h expected 0", o_core_a); end
    rx_q.delete(); tx_log.delete(); exp_tx.delete(); exp_a_q.delete(); result_q.delete();
    @(posedge i_clk); #2;
    i_rst = 1'b1;
    s0 = start_cnt;
    push_random_block(n_new);
    push_random_block(d_new);
    push_random_block(a_new);
    exp_n = n_new;
    exp_d = d_new;
    exp_a_q.push_back(a_new);
    ok = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge i_clk); #2;
      if (start_cnt != s0) begin ok = 1; break; end
    end
    checks += 3;
    if (!ok)               begin failures++; $display("[TB] FAIL reload_start_timeout: got no start expected 1"); end
    if (o_core_n !== n_new) begin failures++; $display("[TB] FAIL reload_n: got %h expected %h", o_core_n, n_new); end
    if (o_core_d !== d_new) begin failures++; $display("[TB] FAIL reload_d: got %h expected %h", o_core_d, d_new); end
    wait_tx(TX_BYTES, 10000, ok);
    repeat (30) @(posedge i_clk);
    #2;
    checks++;
    if (tx_log.size() != TX_BYTES) begin failures++; $display("[TB] FAIL reload_tx_count: got %0d expected %0d", tx_log.size(), TX_BYTES); end
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++) begin
      checks++;
      if (tx_log[i] !== exp_tx[i]) begin failures++; $display("[TB] FAIL reload_tx_byte%0d: got %h expected %h", i, tx_log[i], exp_tx[i]); end
    end
  endtask

  initial begin
    i_rst = 1'b0;
    checks = 0; failures = 0;
    exp_n = '0; exp_d = '0;
    rx_block = 0; polls_since_rx = 0; last_polls = 0; rx_reads = 0; pop_total = 0;
    force_tx_wait = 0; forced_stalls = 0; forced_done = 0; start_cnt = 0;
    test_reset();
    test_known_vectors();
    test_rx_stall();
    test_back_to_back();
    test_tx_stall();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    failures++;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
